// File: rtl/condicionador_botao.sv
// Push-button conditioner: 2-flop synchronizer, press/release debounce and post-release lockout.
// States: OCIOSO idle, FILTRA press filtering, SOLTA waiting for release, BLOQUEIO lockout.
module condicionador_botao #(
  parameter logic [7:0] DEB  = 8'd4,
  parameter logic [7:0] LOCK = 8'd8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bt_raw,
  output logic       bt,
  output logic       ocupado,
  output logic [7:0] npress
);

  typedef enum logic [1:0] {OCIOSO, FILTRA, SOLTA, BLOQUEIO} state_t;

  state_t     state;
  logic       sync1;
  logic       s;
  logic [7:0] cnt;
  logic [7:0] lcnt;
  logic [7:0] cnt_inc;
  logic [7:0] lcnt_inc;
  logic [7:0] npress_sat;

  assign cnt_inc    = cnt + 8'd1;
  assign lcnt_inc   = lcnt + 8'd1;
  assign npress_sat = (npress == 8'hFF) ? npress : npress + 8'd1;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
    end else begin
      sync1 <= bt_raw;
      s     <= sync1;
    end
  end

  // Counters are cleared on the same edge they reach their terminal value, so they never exceed it.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= OCIOSO;
      cnt     <= 8'd0;
      lcnt    <= 8'd0;
      bt      <= 1'b0;
      ocupado <= 1'b0;
      npress  <= 8'd0;
    end else begin
      bt <= 1'b0;
      case (state)
        OCIOSO: begin
          if (s) begin
            ocupado <= 1'b1;
            if (DEB == 8'd1) begin
              state  <= SOLTA;
              cnt    <= 8'd0;
              bt     <= 1'b1;
              npress <= npress_sat;
            end else begin
              state <= FILTRA;
              cnt   <= 8'd1;
            end
          end else begin
            cnt     <= 8'd0;
            ocupado <= 1'b0;
          end
        end
        FILTRA: begin
          if (!s) begin
            state   <= OCIOSO;
            cnt     <= 8'd0;
            ocupado <= 1'b0;
          end else if (cnt_inc == DEB) begin
            state  <= SOLTA;
            cnt    <= 8'd0;
            bt     <= 1'b1;
            npress <= npress_sat;
          end else begin
            cnt <= cnt_inc;
          end
        end
        SOLTA: begin
          if (s) begin
            cnt <= 8'd0;
          end else if (cnt_inc == DEB) begin
            state <= BLOQUEIO;
            cnt   <= 8'd0;
            lcnt  <= 8'd0;
          end else begin
            cnt <= cnt_inc;
          end
        end
        BLOQUEIO: begin
          if (lcnt_inc == LOCK) begin
            state   <= OCIOSO;
            cnt     <= 8'd0;
            lcnt    <= 8'd0;
            ocupado <= 1'b0;
          end else begin
            lcnt <= lcnt_inc;
          end
        end
        default: begin
          state   <= OCIOSO;
          cnt     <= 8'd0;
          lcnt    <= 8'd0;
          ocupado <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_condicionador_botao.sv
// Bench for condicionador_botao: window-based reference model of press/release/lockout timing.
module tb_condicionador_botao;
  localparam int DEB  = 4;
  localparam int LOCK = 8;
  localparam int HMAX = 16384;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       bt_raw = 1'b0;
  logic       bt;
  logic       ocupado;
  logic [7:0] npress;

  condicionador_botao #(.DEB(8'(DEB)), .LOCK(8'(LOCK))) dut (
    .clk(clk), .rst(rst), .bt_raw(bt_raw),
    .bt(bt), .ocupado(ocupado), .npress(npress)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int dut_pulses = 0;

  // Model: s seen at edge t is bt_raw taken at edge t-2; a press needs DEB ones after arming,
  // a release DEB zeros after the pulse, then LOCK edges are ignored.
  bit raw_h [HMAX];
  int t, phase, arm, lock_end, rel_start, np;
  bit exp_bt, exp_busy;

  function automatic bit window_is(input bit val, input int from, input int to);
    for (int i = from; i <= to; i++) if (s_at(i) != val) return 1'b0;
    return 1'b1;
  endfunction

  function automatic bit s_at(input int e);
    return (e >= 2) ? raw_h[e-2] : 1'b0;
  endfunction

  task automatic model_init();
    t = -1; phase = 0; arm = 0; lock_end = -1; rel_start = 0; np = 0;
  endtask

  task automatic model_edge(input bit v);
    t++;
    if (t >= HMAX) $fatal(1, "FAIL history: model history overflow at edge %0d", t);
    raw_h[t] = v;
    exp_bt = 1'b0;
    if (phase == 0 && t - DEB + 1 >= arm && window_is(1'b1, t - DEB + 1, t)) begin
      exp_bt = 1'b1;
      phase = 1;
      rel_start = t + 1;
      if (np < 255) np++;
    end else if (phase == 1 && t - DEB + 1 >= rel_start && window_is(1'b0, t - DEB + 1, t)) begin
      phase = 0;
      lock_end = t + LOCK;
      arm = lock_end + 1;
    end
    exp_busy = (phase == 1) || (t < lock_end) || (t >= arm && s_at(t));
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (time %0t)", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic v);
    bt_raw = v;
    @(posedge clk); #1;
    model_edge(v);
    if (bt) dut_pulses++;
    chk("bt", 32'(bt), 32'(exp_bt));
    chk("ocupado", 32'(ocupado), 32'(exp_busy));
    chk("npress", 32'(npress), 32'(np));
  endtask

  task automatic do_reset(input logic raw_v);
    @(negedge clk);
    bt_raw = raw_v;
    rst = 1'b0;
    #1;
    chk("rst_bt", 32'(bt), 32'd0);
    chk("rst_ocupado", 32'(ocupado), 32'd0);
    chk("rst_npress", 32'(npress), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    model_init();
  endtask

  typedef struct {
    logic [31:0] pat;
    int          len;
    int          exp_pulses;
  } vec_t;

  vec_t vt [8];
  int p0;

  initial begin
    vt[0] = '{32'h0000_0003,  2, 0};   // glitch
    vt[1] = '{32'h0000_0007,  3, 0};   // one sample short
    vt[2] = '{32'h0000_000F,  4, 1};   // exactly DEB samples
    vt[3] = '{32'h0000_0077,  7, 0};   // runs broken by a zero
    vt[4] = '{32'h0000_00FF,  8, 1};
    vt[5] = '{32'h0000_0F55, 12, 1};   // bounce then steady
    vt[6] = '{32'h000F_000F, 20, 2};   // re-press right at lockout exit
    vt[7] = '{32'h0007_800F, 19, 1};   // re-press one edge inside lockout

    model_init();
    do_reset(1'b0);

    // Clean press held 20 cycles
    p0 = dut_pulses;
    for (int i = 0; i < 20; i++) step(1'b1);
    for (int i = 0; i < 20; i++) step(1'b0);
    chk("held_pulses", 32'(dut_pulses - p0), 32'd1);
    chk("held_npress", 32'(npress), 32'd1);

    foreach (vt[k]) begin
      p0 = dut_pulses;
      for (int i = 0; i < vt[k].len; i++) begin
        logic [31:0] pv;
        pv = vt[k].pat;
        step(pv[i]);
      end
      for (int i = 0; i < 30; i++) step(1'b0);
      chk($sformatf("vec%0d_pulses", k), 32'(dut_pulses - p0), 32'(vt[k].exp_pulses));
    end

    // Lockout: re-press inside BLOQUEIO is ignored
    do_reset(1'b0);
    p0 = dut_pulses;
    for (int i = 0; i < 6; i++) step(1'b1);
    for (int i = 0; i < 4; i++) step(1'b0);
    for (int i = 0; i < 3; i++) step(1'b1);
    for (int i = 0; i < 25; i++) step(1'b0);
    chk("lock_ignored_pulses", 32'(dut_pulses - p0), 32'd1);

    // Lockout: re-press held across BLOQUEIO exit gives a second pulse
    do_reset(1'b0);
    p0 = dut_pulses;
    for (int i = 0; i < 6; i++) step(1'b1);
    for (int i = 0; i < 4; i++) step(1'b0);
    for (int i = 0; i < 20; i++) step(1'b1);
    for (int i = 0; i < 20; i++) step(1'b0);
    chk("lock_held_pulses", 32'(dut_pulses - p0), 32'd2);
    chk("lock_held_npress", 32'(npress), 32'd2);

    // Random run-length stimulus
    do_reset(1'b0);
    for (int r = 0; r < 150; r++) begin
      logic lv;
      int   n;
      lv = 1'($urandom_range(1, 0));
      n  = $urandom_range(12, 1);
      for (int i = 0; i < n; i++) step(lv);
    end
    for (int i = 0; i < 20; i++) step(1'b0);

    // Saturation of npress
    do_reset(1'b0);
    for (int k = 1; k <= 260; k++) begin
      p0 = dut_pulses;
      for (int i = 0; i < 5; i++) step(1'b1);
      for (int i = 0; i < 14; i++) step(1'b0);
      chk("sat_pulse", 32'(dut_pulses - p0), 32'd1);
      chk("sat_npress", 32'(npress), 32'((k > 255) ? 255 : k));
    end

    // Async reset between edges while in FILTRA
    for (int i = 0; i < 3; i++) step(1'b1);
    chk("pre_rst_ocupado", 32'(ocupado), 32'd1);
    #2;
    rst = 1'b0;
    bt_raw = 1'b0;
    #1;
    chk("async_bt", 32'(bt), 32'd0);
    chk("async_ocupado", 32'(ocupado), 32'd0);
    chk("async_npress", 32'(npress), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    model_init();
    p0 = dut_pulses;
    for (int i = 0; i < 20; i++) step(1'b0);
    chk("post_rst_pulses", 32'(dut_pulses - p0), 32'd0);

    // Reset while held: a still-pressed button needs DEB fresh samples
    for (int i = 0; i < 4; i++) step(1'b1);
    do_reset(1'b1);
    p0 = dut_pulses;
    for (int i = 0; i < 5; i++) step(1'b1);
    chk("held_rst_early", 32'(dut_pulses - p0), 32'd0);
    step(1'b1);
    chk("held_rst_pulse", 32'(dut_pulses - p0), 32'd1);
    for (int i = 0; i < 20; i++) step(1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/condicionador_botao.md
CONDICIONADOR_BOTAO -- requirements
Module: condicionador_botao

Interface
REQ-001 Parameter DEB, default 8'd4, number of consecutive equal synchronized samples that confirm a press or a release (legal 1..255).
REQ-002 Parameter LOCK, default 8'd8, lockout cycles after a confirmed release, during which input is ignored (legal 1..255).
REQ-003 clk  input  1  single system clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (rst=0 resets immediately, release is synchronous to clk).
REQ-005 bt_raw  input  1  raw, asynchronous, bouncing pedestrian push-button, 1 = pressed.
REQ-006 bt  output  1  conditioned single-cycle press pulse, feeds the traffic-light controller's bt input.
REQ-007 ocupado  output  1  1 whenever the FSM is not in OCIOSO.
REQ-008 npress  output  8  count of bt pulses issued since reset, saturating.

Function
REQ-009 bt_raw SHALL pass through a 2-flop synchronizer; the FSM SHALL sample only the second flop output s.
REQ-010 FSM states: OCIOSO, FILTRA, SOLTA, BLOQUEIO; one 8-bit stability counter cnt; one 8-bit lockout counter lcnt.
REQ-011 OCIOSO: s=0 -> stay, cnt=0; s=1 -> cnt=1 and go FILTRA, or go SOLTA with pulse directly if DEB=1.
REQ-012 FILTRA: s=0 -> OCIOSO, cnt=0 (no pulse); s=1 -> cnt+1; on the edge where cnt+1 equals DEB, go SOLTA, cnt=0, bt=1.
REQ-013 bt SHALL be registered, high for exactly one clock cycle per confirmed press, never two consecutive cycles.
REQ-014 Latency: if s is first sampled 1 at edge n and stays 1, bt SHALL rise at edge n+DEB-1 (bt_raw sampled at edge m gives s at edge m+1).
REQ-015 SOLTA: s=1 -> cnt=0, stay; s=0 -> cnt+1; on the edge where cnt+1 equals DEB, go BLOQUEIO, lcnt=0.
REQ-016 A press held indefinitely SHALL produce only one bt pulse; FSM remains in SOLTA.
REQ-017 BLOQUEIO: lcnt+1 every cycle regardless of s; on the edge where lcnt+1 equals LOCK, go OCIOSO, cnt=0.
REQ-018 Any s activity in BLOQUEIO SHALL be ignored; if s=1 on return to OCIOSO, a new press is filtered normally per REQ-011.
REQ-019 npress SHALL increment on the same edge that sets bt=1 and saturate at 255 (no wrap).
REQ-020 Counters SHALL never exceed DEB or LOCK; no arithmetic wrap in any state.
REQ-021 ocupado SHALL be a registered decode of state (1 in FILTRA, SOLTA, BLOQUEIO).

Reset
REQ-022 rst=0 SHALL force immediately: state OCIOSO, cnt=0, lcnt=0, synchronizer flops 0, bt=0, ocupado=0, npress=0.
REQ-023 Reset mid-press (any state) SHALL abort with no pulse; after release, a still-pressed button is treated as a new press requiring DEB fresh samples.
REQ-024 A pending bt pulse at the instant rst falls SHALL be cleared at once.

Verification
REQ-025 DEB=4, LOCK=8: rst low 1 cycle, bt_raw=1 held 20 cycles -> exactly one bt pulse, 5 edges after bt_raw first sampled (2 sync + DEB-1), npress=1.
REQ-026 Glitch: bt_raw high 2 cycles then low -> no bt pulse, FSM returns OCIOSO, ocupado high then low, npress=0.
REQ-027 Bounce: bt_raw toggling every cycle 6 cycles then steady high -> single pulse DEB samples after steady, npress=1.
REQ-028 Lockout: press, release 4 cycles, re-press within the 8 BLOQUEIO cycles and release before exit -> no second pulse; re-press held past BLOQUEIO exit -> second pulse, npress=2.
REQ-029 Saturation: 260 clean presses -> npress=255 after the 255th, stays 255; bt still pulses each press.
REQ-030 Async reset: assert rst between clock edges during FILTRA -> bt, ocupado, npress zero before next edge; no pulse emitted after release while bt_raw low.
